// File: rtl/binary_to_octal_stream.sv
// Streaming 3-to-8 one-hot decoder: codes enter through a 2-entry FIFO
// and leave as one-hot words on a valid/ready port, with a transfer counter.
module binary_to_octal_stream #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       in_code,
   input  logic             in_en,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] xfer_count
);

   // Each entry is {en, code}; contents are never reset, out is gated by occupancy.
   logic [3:0]       mem_reg [0:1];
   logic             rd_ptr_reg;
   logic             wr_ptr_reg;
   logic [1:0]       occ_reg;
   logic [1:0]       occ_next;
   logic             in_ready_reg;
   logic [CNT_W-1:0] xfer_count_reg;
   logic             push;
   logic             pop;
   logic [3:0]       head;

   assign push = in_valid && in_ready_reg;
   assign pop  = (occ_reg != 2'd0) && out_ready;

   always_comb begin
      occ_next = occ_reg;
      case ({push, pop})
         2'b10:   occ_next = occ_reg + 2'd1;
         2'b01:   occ_next = occ_reg - 2'd1;
         default: occ_next = occ_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= {in_en, in_code};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_reg     <= 1'b0;
         wr_ptr_reg     <= 1'b0;
         occ_reg        <= 2'd0;
         in_ready_reg   <= 1'b1;
         xfer_count_reg <= '0;
      end else begin
         occ_reg <= occ_next;
         // Registered so out_ready never reaches in_ready combinationally.
         in_ready_reg <= (occ_next < 2'd2);
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg     <= ~rd_ptr_reg;
            xfer_count_reg <= xfer_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign head       = mem_reg[rd_ptr_reg];
   assign out_valid  = (occ_reg != 2'd0);
   assign in_ready   = in_ready_reg;
   assign xfer_count = xfer_count_reg;

   for (genvar gi = 0; gi < 8; gi++) begin : g_decode
      assign out[gi] = out_valid && head[3] && (head[2:0] == 3'(gi));
   end

endmodule

// File: doc/binary_to_octal_stream.md
# binary_to_octal_stream

Streaming 3-to-8 one-hot decoder: the inverse of the team's 8-to-3 octal-to-binary encoder. It accepts 3-bit codes over a valid/ready handshake, buffers them in a 2-entry FIFO, and presents each as an 8-bit one-hot word on a valid/ready output port. A transfer counter gives observability. It sits between a code producer (e.g. an encoder output stage) and any consumer of one-hot select lines.

## Interface
- CNT_W, 8, width of the output-transfer counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_code  input  3  binary code 0..7.
- in_en  input  1  1 = decode in_code; 0 = emit all-zero word, in_code ignored.
- in_valid  input  1  producer has a code.
- in_ready  output  1  block can accept; registered.
- out  output  8  one-hot word for the FIFO head; 8'h00 when empty.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts.
- xfer_count  output  CNT_W  completed output transfers; wraps.

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Push {in_en, in_code} into the FIFO.
- Output transfer: out_valid && out_ready at a rising edge. Pop the head and increment xfer_count.
- FIFO: 2 entries, with a read pointer, a write pointer and a 2-bit occupancy (0..2). Pointers are 1 bit and wrap 1->0.
- Decode (combinational from head entry):
  - en=1: out[k] = 1 exactly when code == k. Codes 0..7 map to 8'h01, 02, 04, 08, 10, 20, 40, 80.
  - en=0: 8'h00.
  - Empty FIFO: out = 8'h00 regardless of stale storage.
- out_valid = (occupancy != 0).
- in_ready is a register. Its next value is 1 when next occupancy < 2.
- Occupancy update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- Full (occupancy 2):
  - in_ready = 0, so no push occurs.
  - A pop brings in_ready back to 1 on the following edge, not combinationally.
- Empty (occupancy 0): out_valid = 0. out_ready is ignored and xfer_count holds.
- xfer_count: +1 per output transfer, modulo 2^CNT_W (255 -> 0 for CNT_W=8).
- Producer behaviour while in_ready=0 is a don't-care. The block must not push.
- Reset (rst_n low, asynchronous, any cycle including mid-transfer):
  - occupancy = 0, pointers = 0, xfer_count = 0.
  - out_valid = 0, out = 8'h00, in_ready = 1.
  - Buffered entries are discarded. Storage contents are don't-care but must never appear on out.

## Timing
- Latency when empty: code accepted at edge N. out_valid = 1 and out decoded after edge N, i.e. visible in cycle N+1.
- No combinational path from in_* to out or out_valid.
- No combinational path from out_ready to in_ready.
- Sustained throughput is 1 transfer/cycle when out_ready stays high. The FIFO then holds 1 entry, with simultaneous push and pop every cycle.
- Back-pressure: with out_ready = 0, at most 2 codes are accepted. in_ready falls after the 2nd accept edge.
- out, out_valid, xfer_count and in_ready change only on clk edges or on rst_n assertion.
- rst_n deassertion is assumed synchronous to clk at the system level. First accept is possible on the first edge after deassertion.

## Test plan
- Reset values: hold rst_n = 0 for 3 cycles, with in_valid = 1 and out_ready = 1. Required: out = 00, out_valid = 0, in_ready = 1, xfer_count = 0; no transfers occur.
- Full decode sweep: out_ready = 1, stream codes 0..7 with in_en = 1 on consecutive cycles, then one word with in_en = 0 and code = 5. Required:
  - out = 01, 02, 04, 08, 10, 20, 40, 80, 00, each one cycle after its accept edge.
  - xfer_count ends at 9.
- Back-pressure and full:
  - out_ready = 0; offer codes 3, 6, 1. Required: 3 and 6 accepted; in_ready = 0 after the 2nd accept; 1 is held off; out = 08 steady.
  - Then raise out_ready for 1 cycle. Required: out becomes 40; in_ready returns to 1 one edge later; 1 is accepted next and appears as 02 after 6.
- Simultaneous push and pop: with 1 entry held (code 2, out = 04), assert in_valid (code 7) and out_ready in the same cycle. Required: occupancy stays 1; out = 80 next cycle; xfer_count increments by 1.
- Counter wrap: 256 transfers of code 0 with CNT_W = 8. Required: xfer_count reads 255 then wraps to 0; out = 01 on each transfer.
- Reset mid-operation: FIFO full with codes 4 and 5; assert rst_n low between edges. Required: out_valid = 0, out = 00 and in_ready = 1 immediately (asynchronously); neither code appears on out after release.
